// File: rtl/xsim_dma_pkg.sv
// Shared widths and helpers for the simulated-DMA port arbiter.
package xsim_dma_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Client ID width; never below one bit so a two-client build still has a real index.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/xsim_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching upward from a registered
// pointer; the pointer moves past the winner only when a grant is made.
module xsim_rr_arbiter
  import xsim_dma_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  localparam int CW = id_width(NUM_CLIENTS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   advance,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [CW-1:0]          grant_idx,
  output logic                   granted
);
  logic [CW-1:0] ptr;

  // First requester at or after ptr, wrapping mod NUM_CLIENTS.
  always_comb begin
    int idx;
    logic [CW-1:0] idx_w;
    grant     = '0;
    grant_idx = '0;
    granted   = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      idx_w = CW'(idx);
      if (advance && !granted && req[idx_w]) begin
        granted      = 1'b1;
        grant_idx    = idx_w;
        grant[idx_w] = 1'b1;
      end
    end
  end

  // Pointer moves to the client after the winner; explicit wrap handles non-power-of-two counts.
  always_ff @(posedge CLK) begin
    if (RST) ptr <= '0;
    else if (granted)
      ptr <= (int'(grant_idx) == NUM_CLIENTS - 1) ? '0 : grant_idx + CW'(1);
  end
endmodule

// File: rtl/xsim_dma_arbiter.sv
// Shares the simulated-DMA read/write port between NUM_CLIENTS requesters.
// Reads and writes arbitrate independently; read responses return in issue
// order and are steered back using an in-order FIFO of client IDs.
module xsim_dma_arbiter
  import xsim_dma_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int TAG_DEPTH   = 4,
  localparam int CW = id_width(NUM_CLIENTS),
  localparam int PW = $clog2(TAG_DEPTH)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_CLIENTS-1:0]        rd_req_valid,
  output logic [NUM_CLIENTS-1:0]        rd_req_ready,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] rd_req_addr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] rd_req_handle,
  input  logic [NUM_CLIENTS-1:0]        wr_valid,
  output logic [NUM_CLIENTS-1:0]        wr_ready,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] wr_addr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] wr_handle,
  input  logic [NUM_CLIENTS*DATA_W-1:0] wr_data,
  input  logic [NUM_CLIENTS*BE_W-1:0]   wr_be,
  output logic [NUM_CLIENTS-1:0]        rsp_valid,
  input  logic [NUM_CLIENTS-1:0]        rsp_ready,
  output logic [DATA_W-1:0]             rsp_data,
  input  logic                          dma_rdy_readrequest,
  output logic                          dma_en_readrequest,
  output logic [ADDR_W-1:0]             dma_readrequest_addr,
  output logic [ADDR_W-1:0]             dma_readrequest_handle,
  input  logic                          dma_rdy_readresponse,
  output logic                          dma_en_readresponse,
  input  logic [DATA_W-1:0]             dma_readresponse_data,
  output logic                          dma_en_write32,
  output logic [ADDR_W-1:0]             dma_write32_addr,
  output logic [ADDR_W-1:0]             dma_write32_handle,
  output logic [DATA_W-1:0]             dma_write32_data,
  output logic [BE_W-1:0]               dma_write32_byteenable,
  output logic [PW:0]                   outstanding
);
  // Per-client views of the flattened buses.
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] rd_addr_v, rd_hdl_v, wr_addr_v, wr_hdl_v;
  logic [NUM_CLIENTS-1:0][DATA_W-1:0] wr_data_v;
  logic [NUM_CLIENTS-1:0][BE_W-1:0]   wr_be_v;
  assign rd_addr_v = rd_req_addr;
  assign rd_hdl_v  = rd_req_handle;
  assign wr_addr_v = wr_addr;
  assign wr_hdl_v  = wr_handle;
  assign wr_data_v = wr_data;
  assign wr_be_v   = wr_be;

  // Tag FIFO state.
  logic [CW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0] tag_wp, tag_rp;
  logic [PW:0]   count;
  logic [CW-1:0] head;
  logic          resp_avail, pop, push, full_eff, rd_adv;

  logic [CW-1:0] rd_idx, wr_idx;
  logic          rd_granted, wr_granted;

  assign head       = tag_mem[tag_rp];
  assign resp_avail = !RST && dma_rdy_readresponse && (count != '0);
  assign pop        = resp_avail && rsp_ready[head];
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
  assign full_eff   = (count == (PW+1)'(TAG_DEPTH)) && !pop;
  assign rd_adv     = !RST && dma_rdy_readrequest && !full_eff;
  assign push       = rd_granted;

  xsim_rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_rd_arb (
    .CLK(CLK), .RST(RST), .req(rd_req_valid), .advance(rd_adv),
    .grant(rd_req_ready), .grant_idx(rd_idx), .granted(rd_granted)
  );

  // DMA writes have no backpressure; only reset holds the write side off.
  xsim_rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_wr_arb (
    .CLK(CLK), .RST(RST), .req(wr_valid), .advance(!RST),
    .grant(wr_ready), .grant_idx(wr_idx), .granted(wr_granted)
  );

  assign dma_en_readrequest     = rd_granted;
  assign dma_readrequest_addr   = rd_addr_v[rd_idx];
  assign dma_readrequest_handle = rd_hdl_v[rd_idx];
  assign dma_en_write32         = wr_granted;
  assign dma_write32_addr       = wr_addr_v[wr_idx];
  assign dma_write32_handle     = wr_hdl_v[wr_idx];
  assign dma_write32_data       = wr_data_v[wr_idx];
  assign dma_write32_byteenable = wr_be_v[wr_idx];

  // Steer the head response to the client that issued it.
  always_comb begin
    rsp_valid = '0;
    if (resp_avail) rsp_valid[head] = 1'b1;
  end

  assign rsp_data            = RST ? '0 : dma_readresponse_data;
  assign dma_en_readresponse = pop;
  assign outstanding         = count;

  // Record the winning client ID for each issued read.
  always_ff @(posedge CLK) begin
    if (push) tag_mem[tag_wp] <= rd_idx;
  end

  // FIFO pointers and occupancy; reset drops all in-flight tags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_wp <= '0;
      tag_rp <= '0;
      count  <= '0;
    end else begin
      if (push) tag_wp <= tag_wp + PW'(1);
      if (pop)  tag_rp <= tag_rp + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding cannot be routed and means the DMA model misbehaved.
  always_ff @(posedge CLK) begin
    if (!RST && dma_rdy_readresponse && count == '0)
      $error("xsim_dma_arbiter: read response with no outstanding request");
  end
`endif
endmodule
